reg_timer: RTL

Programmable down-counting timer exposed as a four-word register file. Sits directly downstream of the AXI register bridge and connects to its `reg_ifc` master port as `reg_ifc.slave`, serving one-cycle-latency reads and single-cycle writes. Produces a level interrupt for the PS interrupt controller.

---
 rtl/reg_timer_pkg.sv | 35 +++
 rtl/reg_timer_if.sv | 18 +
 rtl/reg_timer_tick_gen.sv | 43 ++++
 rtl/reg_timer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/reg_timer_pkg.sv
// Shared constants, types and helpers for the reg_timer register block.
package reg_timer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NEXP_W = 16;

    // Register word indices
    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_LOAD   = 1;
    localparam int unsigned REG_COUNT  = 2;
    localparam int unsigned REG_STATUS = 3;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_AUTO_BIT = 1;
    localparam int unsigned CTRL_IE_BIT   = 2;

    // STATUS fields
    localparam int unsigned STATUS_EXP_BIT = 0;
    localparam int unsigned NEXP_LSB       = 16;
    localparam int unsigned NEXP_MSB       = 31;

    // Field order matches the CTRL bit positions (ie is bit 2, en is bit 0)
    typedef struct packed {
        logic ie;
        logic auto_rl;
        logic en;
    } ctrl_t;

    // Saturating increment of the expiry counter
    function automatic logic [NEXP_W-1:0] nexp_inc(input logic [NEXP_W-1:0] v);
        return (&v) ? v : v + NEXP_W'(1);
    endfunction

endpackage

// File: rtl/reg_timer_if.sv
// Simple register bus: one-cycle-latency reads, single-cycle writes.
interface reg_ifc
    import reg_timer_pkg::*;
#(
    parameter int unsigned R_ADDR_WIDTH = 2
) ();

    logic                    rd;
    logic [R_ADDR_WIDTH-1:0] raddr;
    logic [DATA_W-1:0]       rdata;
    logic                    wr;
    logic [R_ADDR_WIDTH-1:0] waddr;
    logic [DATA_W-1:0]       wdata;

    modport master (output rd, raddr, wr, waddr, wdata, input rdata);
    modport slave  (input rd, raddr, wr, waddr, wdata, output rdata);

endinterface

// File: rtl/reg_timer_tick_gen.sv
// Prescaler: one tick per PRESCALE enabled cycles; pass-through when PRESCALE is 1.
module tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    if (PRESCALE <= 1) begin : g_bypass
        logic unused_inputs;
        assign unused_inputs = ^{clk, reset, restart};
        assign tick = en;
    end else begin : g_div
        localparam int unsigned CW = $clog2(PRESCALE);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // Tick on terminal count; counter held at 0 while disabled or restarted
        always_comb begin
            cnt_d = cnt_q;
            tick  = en && (cnt_q == CW'(PRESCALE - 1));
            if (!en || restart || tick) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Prescale counter register
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

endmodule

// File: rtl/reg_timer.sv
// Programmable down-counting timer with CTRL/LOAD/COUNT/STATUS registers and a level irq.
module reg_timer
    import reg_timer_pkg::*;
#(
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned R_ADDR_WIDTH = 2
) (
    input  logic  clk,
    input  logic  reset,
    reg_ifc.slave r,
    output logic  irq
);

    localparam logic [R_ADDR_WIDTH-1:0] A_CTRL   = R_ADDR_WIDTH'(REG_CTRL);
    localparam logic [R_ADDR_WIDTH-1:0] A_LOAD   = R_ADDR_WIDTH'(REG_LOAD);
    localparam logic [R_ADDR_WIDTH-1:0] A_COUNT  = R_ADDR_WIDTH'(REG_COUNT);
    localparam logic [R_ADDR_WIDTH-1:0] A_STATUS = R_ADDR_WIDTH'(REG_STATUS);
    localparam int unsigned             PAD_W    = DATA_W - NEXP_W - 1;

    ctrl_t             ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] load_q,  load_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic              exp_q,   exp_d;
    logic [NEXP_W-1:0] nexp_q,  nexp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              irq_q,   irq_d;

    logic wr_ctrl, wr_load, wr_status, rd_status;
    logic en_set, en_rise, tick, expire;

    assign wr_ctrl   = r.wr && (r.waddr == A_CTRL);
    assign wr_load   = r.wr && (r.waddr == A_LOAD);
    assign wr_status = r.wr && (r.waddr == A_STATUS);
    assign rd_status = r.rd && (r.raddr == A_STATUS);
    assign en_set    = wr_ctrl && r.wdata[CTRL_EN_BIT];
    assign en_rise   = en_set && !ctrl_q.en;
    assign expire    = tick && (count_q == '0);

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (ctrl_q.en),
        .restart (en_set),
        .tick    (tick)
    );

    // Register writes, countdown/expiry and read mux, all evaluated on pre-cycle state
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;
        nexp_d  = nexp_q;
        rdata_d = rdata_q;

        if (wr_ctrl) begin
            ctrl_d.en      = r.wdata[CTRL_EN_BIT];
            ctrl_d.auto_rl = r.wdata[CTRL_AUTO_BIT];
            ctrl_d.ie      = r.wdata[CTRL_IE_BIT];
        end
        if (wr_load) begin
            load_d = r.wdata;
        end
        if (wr_status && r.wdata[STATUS_EXP_BIT]) begin
            exp_d = 1'b0;
        end
        if (rd_status) begin
            nexp_d = '0;
        end

        // Expiry wins over W1C and clear-on-read; reload always uses the old LOAD
        if (en_rise) begin
            count_d = load_q;
        end else if (expire) begin
            exp_d  = 1'b1;
            nexp_d = rd_status ? NEXP_W'(1) : nexp_inc(nexp_q);
            if (ctrl_q.auto_rl) begin
                count_d = load_q;
            end else begin
                count_d   = '0;
                ctrl_d.en = 1'b0;
            end
        end else if (tick) begin
            count_d = count_q - DATA_W'(1);
        end

        if (r.rd) begin
            case (r.raddr)
                A_CTRL:   rdata_d = DATA_W'(ctrl_q);
                A_LOAD:   rdata_d = load_q;
                A_COUNT:  rdata_d = count_q;
                A_STATUS: rdata_d = {nexp_q, {PAD_W{1'b0}}, exp_q};
                default:  rdata_d = '0;
            endcase
        end

        irq_d = exp_d && ctrl_d.ie;
    end

    // Register state
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
            nexp_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            nexp_q  <= nexp_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign r.rdata = rdata_q;
    assign irq     = irq_q;

endmodule
